// File: rtl/fp_round_pkg.sv
// -----------------------------------------------------------------------------
// fp_round_pkg
// Shared widths, rounding-mode constants and transport structs for the
// DLFloat16 rounding arbiter.
//   UNRND_W  : width of an unrounded producer result
//   DLF_W    : width of a rounded DLFloat16 value
//   RM_W     : width of a rounding-mode code
//   MAX_ID_W : widest requester ID the arbiter supports (up to 8 requesters)
// -----------------------------------------------------------------------------
package fp_round_pkg;

  localparam int UNRND_W  = 20;
  localparam int DLF_W    = 16;
  localparam int RM_W     = 3;
  localparam int MAX_ID_W = 3;

  localparam logic [RM_W-1:0] RM_TRUNC = 3'b011;

  typedef struct packed {
    logic [UNRND_W-1:0] data;
    logic [RM_W-1:0]    rm;
  } rnd_req_t;

  // The ID field is sized for the largest supported requester count; the
  // arbiter narrows it to its own ID_W on the way out.
  typedef struct packed {
    logic [DLF_W-1:0]    data;
    logic [MAX_ID_W-1:0] id;
  } rnd_resp_t;

endpackage

// File: rtl/fp_round_rr_arb.sv
// -----------------------------------------------------------------------------
// fp_round_rr_arb
// Combinational round-robin grant. The search starts one past last_grant and
// wraps modulo N; the first asserted request wins.
//   req         in  N      request vector
//   enable      in  1      when low no grant is produced
//   last_grant  in  IDX_W  index of the previously granted requester
//   grant       out N      one-hot grant (all zero when nothing is granted)
//   grant_idx   out IDX_W  index of the granted requester
//   grant_valid out 1      a grant is being produced this cycle
// -----------------------------------------------------------------------------
module fp_round_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [IDX_W:0]   start;
  logic [IDX_W:0]   sum;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] offset;
  logic             hit;

  // Rotate the doubled request vector so bit 0 is the highest-priority
  // requester, take the first set bit, then map the offset back to an index.
  always_comb begin
    start  = {1'b0, last_grant} + (IDX_W + 1)'(1);
    rot    = N'({req, req} >> start);
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && rot[i]) begin
        hit    = 1'b1;
        offset = IDX_W'(i);
      end
    end
    sum       = start + {1'b0, offset};
    grant_idx = (sum >= N_W) ? IDX_W'(sum - N_W) : IDX_W'(sum);
  end

  assign grant_valid = hit & enable;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/fp_round_arbiter.sv
// -----------------------------------------------------------------------------
// fp_round_arbiter
// Shares one DLFloat16 rounding unit between NUM_REQ producers. Grants one
// producer per cycle round-robin, tracks in-flight operations by requester ID
// and buffers rounded results in a credit-protected FIFO.
//   clk, rst     clock / synchronous active-high reset
//   req_valid    in  NUM_REQ     producer i offers an operation
//   req_ready    out NUM_REQ     one-hot grant (combinational)
//   req_data     in  NUM_REQ*20  unrounded operands, slice i at [20i+19:20i]
//   req_rm       in  NUM_REQ*3   rounding modes, slice i at [3i+2:3i]
//   rnd_in1      out 20          operand to the rounder (0 when idle)
//   rnd_rm       out 3           rounding mode to the rounder (0 when idle)
//   rnd_out      in  16          rounder result, ROUND_LAT cycles after issue
//   resp_valid   out 1           FIFO head valid
//   resp_ready   in  1           consumer accepts the head
//   resp_data    out 16          rounded result at the FIFO head
//   resp_id      out ID_W        requester index of the head result
// -----------------------------------------------------------------------------
module fp_round_arbiter
  import fp_round_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ROUND_LAT  = 1,
  parameter int FIFO_DEPTH = ROUND_LAT + 2,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*UNRND_W-1:0] req_data,
  input  logic [NUM_REQ*RM_W-1:0]    req_rm,
  output logic [UNRND_W-1:0]         rnd_in1,
  output logic [RM_W-1:0]            rnd_rm,
  input  logic [DLF_W-1:0]           rnd_out,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DLF_W-1:0]           resp_data,
  output logic [ID_W-1:0]            resp_id
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  rnd_req_t             req_slice [NUM_REQ];
  logic [ID_W-1:0]      last_grant_reg;
  logic [ROUND_LAT-1:0] if_valid_reg;
  logic [ID_W-1:0]      if_id_reg [ROUND_LAT];
  rnd_resp_t            mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]     fifo_count_reg;
  int                   inflight;
  logic                 credit_ok;
  logic                 transfer;
  logic                 push;
  logic                 pop;
  logic [ID_W-1:0]      grant_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_slice[gi] = {req_data[gi*UNRND_W +: UNRND_W], req_rm[gi*RM_W +: RM_W]};
  end

  // Credit: every result already buffered or still inside the rounder owns a
  // FIFO slot. A pop in the same cycle is deliberately not counted.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < ROUND_LAT; i++) begin
      inflight += int'(if_valid_reg[i]);
    end
  end

  assign credit_ok = (int'(fifo_count_reg) + inflight) < FIFO_DEPTH;

  fp_round_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arb (
    .req         (req_valid),
    .enable      (credit_ok & ~rst),
    .last_grant  (last_grant_reg),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (transfer)
  );

  always_comb begin
    rnd_in1 = '0;
    rnd_rm  = '0;
    if (transfer) begin
      rnd_in1 = req_slice[grant_idx].data;
      rnd_rm  = req_slice[grant_idx].rm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= ID_W'(NUM_REQ - 1);
    end else if (transfer) begin
      last_grant_reg <= grant_idx;
    end
  end

  // In-flight tracker mirrors the rounder pipeline; it never stalls, so every
  // stage shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_reg <= '0;
      for (int i = 0; i < ROUND_LAT; i++) begin
        if_id_reg[i] <= '0;
      end
    end else begin
      if_valid_reg[0] <= transfer;
      if_id_reg[0]    <= grant_idx;
      for (int i = 1; i < ROUND_LAT; i++) begin
        if_valid_reg[i] <= if_valid_reg[i-1];
        if_id_reg[i]    <= if_id_reg[i-1];
      end
    end
  end

  assign push       = if_valid_reg[ROUND_LAT-1];
  assign resp_valid = (fifo_count_reg != '0);
  assign pop        = resp_valid & resp_ready;

  // Storage has no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= {rnd_out, MAX_ID_W'(if_id_reg[ROUND_LAT-1])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CNT_W'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CNT_W'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Head is forced to zero when empty so nothing stale or unknown leaks out.
  assign resp_data = resp_valid ? mem_reg[rd_ptr_reg].data : '0;
  assign resp_id   = resp_valid ? ID_W'(mem_reg[rd_ptr_reg].id) : '0;

  // Credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      assert (fifo_count_reg < CNT_FULL);
    end
  end

endmodule

// File: tb/tb_fp_round_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_round_arbiter
// Directed bench for fp_round_arbiter with default parameters. A behavioural
// stand-in for fp_round_unit (one-cycle latency) truncates the low nibble for
// RM_TRUNC and rounds half-up on that nibble for any other mode; the expected
// results below are worked out by hand from those two rules.
// -----------------------------------------------------------------------------
module tb_fp_round_arbiter;
  import fp_round_pkg::*;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*20-1:0] req_data;
  logic [N*3-1:0]  req_rm;
  logic [19:0]     rnd_in1;
  logic [2:0]      rnd_rm;
  logic [15:0]     rnd_out;
  logic            resp_valid;
  logic            resp_ready;
  logic [15:0]     resp_data;
  logic [1:0]      resp_id;

  int checks   = 0;
  int failures = 0;

  logic [19:0] rr_data [4] = '{20'h12348, 20'h13348, 20'h14348, 20'h15348};
  logic [2:0]  rr_rm   [4] = '{3'b011, 3'b000, 3'b011, 3'b000};
  logic [15:0] rr_exp  [4] = '{16'h1234, 16'h1335, 16'h1434, 16'h1535};
  logic [3:0]  bp_exp  [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rnd_rm == RM_TRUNC) rnd_out <= rnd_in1[19:4];
    else                    rnd_out <= rnd_in1[19:4] + {15'b0, rnd_in1[3]};
  end

  fp_round_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_rm     (req_rm),
    .rnd_in1    (rnd_in1),
    .rnd_rm     (rnd_rm),
    .rnd_out    (rnd_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready)
      $display("resp id=%0d data=%h t=%0t", resp_id, resp_data, $time);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [19:0] d, input logic [2:0] rm);
    req_data[i*20 +: 20] = d;
    req_rm[i*3 +: 3]     = rm;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_rm     = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, rr_data[i], rr_rm[i]);

    // Reset values, with every requester asking
    cyc();
    cyc();
    req_valid = 4'hF;
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rnd_in1", rnd_in1, 0);
    check_eq("rst_rnd_rm", rnd_rm, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_resp_id", resp_id, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_first_prio", req_ready, 4'b0001);
    req_valid = '0;
    #1;
    check_eq("idle_ready", req_ready, 0);

    // Single request from requester 2, truncation
    set_req(2, 20'h5DFFF, 3'b011);
    resp_ready = 1'b1;
    req_valid  = 4'b0100;
    #1;
    check_eq("single_grant", req_ready, 4'b0100);
    check_eq("single_in1", rnd_in1, 20'h5DFFF);
    check_eq("single_rm", rnd_rm, 3'b011);
    cyc();
    req_valid = '0;
    #1;
    check_eq("single_lat1", resp_valid, 0);
    check_eq("single_idle_in1", rnd_in1, 0);
    cyc();
    check_eq("single_valid", resp_valid, 1);
    check_eq("single_data", resp_data, 16'h5DFF);
    check_eq("single_id", resp_id, 2);
    cyc();
    check_eq("single_popped", resp_valid, 0);

    // Round-robin stream with simultaneous push/pop
    do_reset();
    set_req(2, rr_data[2], rr_rm[2]);
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    #1;
    for (int n = 0; n < 8; n++) begin
      check_eq("rr_grant", req_ready, 32'(1 << (n % 4)));
      check_eq("rr_in1", rnd_in1, rr_data[n % 4]);
      check_eq("rr_rm", rnd_rm, rr_rm[n % 4]);
      if (n >= 2) begin
        check_eq("rr_resp_valid", resp_valid, 1);
        check_eq("rr_resp_id", resp_id, (n - 2) % 4);
        check_eq("rr_resp_data", resp_data, rr_exp[(n - 2) % 4]);
        check_eq("rr_fifo_count", dut.fifo_count_reg, 1);
      end
      cyc();
    end
    req_valid = '0;
    cyc();
    cyc();
    cyc();
    check_eq("rr_drained", resp_valid, 0);

    // Backpressure: three transfers, then credit runs out
    do_reset();
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    #1;
    for (int n = 0; n < 6; n++) begin
      check_eq("bp_ready", req_ready, bp_exp[n]);
      if (n >= 2) begin
        check_eq("bp_head_valid", resp_valid, 1);
        check_eq("bp_head_id", resp_id, 0);
        check_eq("bp_head_data", resp_data, 16'h1234);
      end
      cyc();
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_pop_no_credit", req_ready, 0);
    cyc();
    resp_ready = 1'b0;
    #1;
    check_eq("bp_regrant", req_ready, 4'b1000);
    check_eq("bp_next_id", resp_id, 1);
    check_eq("bp_next_data", resp_data, 16'h1335);
    cyc();
    check_eq("bp_full_again", req_ready, 0);

    // Reset with two results buffered and one in flight
    check_eq("mid_pre_count", dut.fifo_count_reg, 2);
    check_eq("mid_pre_inflight", dut.if_valid_reg, 1);
    rst       = 1'b1;
    req_valid = '0;
    cyc();
    check_eq("mid_rst_valid", resp_valid, 0);
    check_eq("mid_rst_data", resp_data, 0);
    rst        = 1'b0;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      check_eq("mid_no_stale", resp_valid, 0);
      cyc();
    end

    // Sparse requests from 1 and 3 after reset (last_grant = 3)
    do_reset();
    set_req(1, 20'hABCD7, 3'b011);
    set_req(3, 20'h0123F, 3'b000);
    resp_ready = 1'b1;
    req_valid  = 4'b1010;
    #1;
    check_eq("sp_grant1", req_ready, 4'b0010);
    check_eq("sp_in1_1", rnd_in1, 20'hABCD7);
    cyc();
    check_eq("sp_grant3", req_ready, 4'b1000);
    check_eq("sp_in1_3", rnd_in1, 20'h0123F);
    check_eq("sp_rm_3", rnd_rm, 3'b000);
    check_eq("sp_no_resp_yet", resp_valid, 0);
    cyc();
    req_valid = '0;
    #1;
    check_eq("sp_idle", req_ready, 0);
    check_eq("sp_resp1_valid", resp_valid, 1);
    check_eq("sp_resp1_id", resp_id, 1);
    check_eq("sp_resp1_data", resp_data, 16'hABCD);
    cyc();
    check_eq("sp_resp3_valid", resp_valid, 1);
    check_eq("sp_resp3_id", resp_id, 3);
    check_eq("sp_resp3_data", resp_data, 16'h0124);
    cyc();
    check_eq("sp_empty", resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
